// File: rtl/toy_pkg.sv
// Shared constants and types for the toy fetch/decode front end:
// instruction field positions, opcodes, FSM encoding and pipeline-register layouts.
package toy_pkg;

    localparam int unsigned XLen  = 32;
    localparam int unsigned AddrW = 30;
    localparam int unsigned RegAw = 5;

    localparam int unsigned OpcodeHi = 31;
    localparam int unsigned OpcodeLo = 27;
    localparam int unsigned RaHi     = 26;
    localparam int unsigned RaLo     = 22;
    localparam int unsigned RbHi     = 21;
    localparam int unsigned RbLo     = 17;
    localparam int unsigned RcHi     = 16;
    localparam int unsigned RcLo     = 12;
    localparam int unsigned Imm17Hi  = 16;
    localparam int unsigned Imm22Hi  = 21;
    localparam int unsigned ShamtHi  = 4;

    localparam logic [4:0] OpAddi = 5'd0,  OpAndi = 5'd1,  OpOri  = 5'd2,  OpMovi = 5'd3,
                           OpAdd  = 5'd4,  OpSub  = 5'd5,  OpNeg  = 5'd6,  OpNot  = 5'd7,
                           OpAnd  = 5'd8,  OpOr   = 5'd9,  OpXor  = 5'd10, OpLsr  = 5'd11,
                           OpAsr  = 5'd12, OpShl  = 5'd13, OpRor  = 5'd14, OpBr   = 5'd15,
                           OpBrl  = 5'd16, OpJ    = 5'd17, OpJl   = 5'd18, OpLd   = 5'd19,
                           OpLdr  = 5'd20, OpSt   = 5'd21, OpStr  = 5'd22;

    localparam logic [1:0] StRst = 2'd0, StStart = 2'd1, StRun = 2'd2;

    typedef struct packed {
        logic [4:0]       op;
        logic [RegAw-1:0] dest;
        logic             wen;
        logic             is_load;
        logic [RegAw-1:0] ra0;
        logic [RegAw-1:0] ra1;
        logic [XLen-1:0]  imm;
    } dec_t;

    typedef struct packed {
        logic             valid;
        logic [XLen-1:0]  instr;
        logic [AddrW-1:0] iaddr;
    } ifid_t;

    typedef struct packed {
        logic             valid;
        logic [4:0]       op;
        logic [XLen-1:0]  instr;
        logic [AddrW-1:0] iaddr;
        logic [RegAw-1:0] dest;
        logic             wen;
        logic             is_load;
        logic [XLen-1:0]  vala;
        logic [XLen-1:0]  valb;
        logic [XLen-1:0]  imm;
    } idex_t;

    function automatic logic [XLen-1:0] sext17(input logic [16:0] v);
        return {{(XLen-17){v[16]}}, v};
    endfunction

    function automatic logic [XLen-1:0] sext22(input logic [21:0] v);
        return {{(XLen-22){v[21]}}, v};
    endfunction

endpackage

// File: rtl/toy_frontend_if.sv
// Fetch, redirect, register-file and ID/EX signals of the toy front end.
interface toy_frontend_if;
    import toy_pkg::*;

    logic             IREQ;
    logic [AddrW-1:0] IADDR;
    logic [XLen-1:0]  INSTR;
    logic             REDIR_VALID;
    logic [AddrW-1:0] REDIR_PC;
    logic [RegAw-1:0] RA0;
    logic [RegAw-1:0] RA1;
    logic [XLen-1:0]  DOUT0;
    logic [XLen-1:0]  DOUT1;
    logic             WB_WEN;
    logic [RegAw-1:0] WB_WA;
    logic [XLen-1:0]  WB_DI;
    logic             ID_VALID;
    logic [4:0]       ID_OP;
    logic [XLen-1:0]  ID_INSTR;
    logic [AddrW-1:0] ID_IADDR;
    logic [RegAw-1:0] ID_DEST;
    logic             ID_WEN;
    logic [XLen-1:0]  ID_VALA;
    logic [XLen-1:0]  ID_VALB;
    logic [XLen-1:0]  ID_IMM;
    logic             STALL;

    modport master (
        output IREQ, IADDR, RA0, RA1, STALL,
        output ID_VALID, ID_OP, ID_INSTR, ID_IADDR, ID_DEST, ID_WEN, ID_VALA, ID_VALB, ID_IMM,
        input  INSTR, REDIR_VALID, REDIR_PC, DOUT0, DOUT1, WB_WEN, WB_WA, WB_DI
    );

    modport slave (
        input  IREQ, IADDR, RA0, RA1, STALL,
        input  ID_VALID, ID_OP, ID_INSTR, ID_IADDR, ID_DEST, ID_WEN, ID_VALA, ID_VALB, ID_IMM,
        output INSTR, REDIR_VALID, REDIR_PC, DOUT0, DOUT1, WB_WEN, WB_WA, WB_DI
    );

endinterface

// File: rtl/toy_decode.sv
// Combinational instruction decoder: register read addresses, immediate
// selection and write-enable for the instruction held in IF/ID.
module toy_decode
    import toy_pkg::*;
(
    input  logic [XLen-1:0] instr,
    input  logic            valid,
    output dec_t            dec
);

    logic [4:0] opc;

    assign opc = instr[OpcodeHi:OpcodeLo];

    always_comb begin
        dec      = '0;
        dec.op   = opc;
        dec.dest = instr[RaHi:RaLo];
        dec.ra0  = instr[RbHi:RbLo];
        dec.ra1  = instr[RcHi:RcLo];
        dec.imm  = sext17(instr[Imm17Hi:0]);

        // Stores and conditional branches read ra as their second operand.
        case (opc)
            OpSt, OpStr, OpBr, OpBrl: dec.ra1 = instr[RaHi:RaLo];
            default: ;
        endcase

        case (opc)
            OpJ, OpJl, OpLdr, OpStr:    dec.imm = sext22(instr[Imm22Hi:0]);
            OpLsr, OpAsr, OpShl, OpRor: dec.imm = {{(XLen-ShamtHi-1){1'b0}}, instr[ShamtHi:0]};
            default: ;
        endcase

        case (opc)
            OpAddi, OpAndi, OpOri, OpMovi, OpAdd, OpSub, OpNeg, OpNot, OpAnd, OpOr, OpXor,
            OpLsr, OpAsr, OpShl, OpRor, OpBrl, OpJl, OpLd, OpLdr: dec.wen = valid;
            default: dec.wen = 1'b0;
        endcase

        dec.is_load = valid && ((opc == OpLd) || (opc == OpLdr));
    end

endmodule

// File: rtl/toy_frontend.sv
// Two-stage fetch/decode front end: PC and start-up FSM, IF/ID and ID/EX registers,
// load-use stall, EX redirect and write-back bypass.
module toy_frontend
    import toy_pkg::*;
(
    input  logic           CLK,
    input  logic           RSTN,
    toy_frontend_if.master bus
);

    logic [1:0]       state_q, state_d;
    logic [AddrW-1:0] pc_q, pc_d;
    ifid_t            ifid_q, ifid_d;
    idex_t            idex_q, idex_d;
    dec_t             dec;
    logic             fetching;
    logic             redir;
    logic             hazard;
    logic             stall;

    toy_decode u_decode (
        .instr (ifid_q.instr),
        .valid (ifid_q.valid),
        .dec   (dec)
    );

    assign fetching = (state_q != StRst);
    assign redir    = fetching && bus.REDIR_VALID;

    // Both read ports are compared; an unneeded stall only costs a cycle.
    assign hazard = ifid_q.valid && idex_q.valid && idex_q.is_load && idex_q.wen &&
                    ((idex_q.dest == dec.ra0) || (idex_q.dest == dec.ra1));
    assign stall  = hazard && !redir;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRst:   state_d = StStart;
            StStart: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redir) begin
            pc_d = bus.REDIR_PC;
        end else if (fetching && !stall) begin
            pc_d = pc_q + AddrW'(1);
        end
    end

    always_comb begin
        ifid_d = ifid_q;
        if (redir || !fetching) begin
            ifid_d = '0;
        end else if (!stall) begin
            ifid_d.valid = 1'b1;
            ifid_d.instr = bus.INSTR;
            ifid_d.iaddr = pc_q;
        end
    end

    always_comb begin
        idex_d = '0;
        if (ifid_q.valid && !stall && !redir) begin
            idex_d.valid   = 1'b1;
            idex_d.op      = dec.op;
            idex_d.instr   = ifid_q.instr;
            idex_d.iaddr   = ifid_q.iaddr;
            idex_d.dest    = dec.dest;
            idex_d.wen     = dec.wen;
            idex_d.is_load = dec.is_load;
            idex_d.imm     = dec.imm;
            idex_d.vala    = (bus.WB_WEN && (bus.WB_WA == dec.ra0)) ? bus.WB_DI : bus.DOUT0;
            idex_d.valb    = (bus.WB_WEN && (bus.WB_WA == dec.ra1)) ? bus.WB_DI : bus.DOUT1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= StRst;
            pc_q    <= '0;
            ifid_q  <= '0;
            idex_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
        end
    end

    assign bus.IREQ     = fetching;
    assign bus.IADDR    = pc_q;
    assign bus.RA0      = dec.ra0;
    assign bus.RA1      = dec.ra1;
    assign bus.STALL    = stall;
    assign bus.ID_VALID = idex_q.valid;
    assign bus.ID_OP    = idex_q.op;
    assign bus.ID_INSTR = idex_q.instr;
    assign bus.ID_IADDR = idex_q.iaddr;
    assign bus.ID_DEST  = idex_q.dest;
    assign bus.ID_WEN   = idex_q.wen;
    assign bus.ID_VALA  = idex_q.vala;
    assign bus.ID_VALB  = idex_q.valb;
    assign bus.ID_IMM   = idex_q.imm;

endmodule

// File: doc/toy_frontend.md
TOY_FRONTEND -- requirements
Module: toy_frontend

Interface
REQ-001 SHALL: CLK  input  1  rising-edge clock; RSTN  input  1  reset, asynchronous, active-low.
REQ-002 SHALL: IREQ  output  1  instruction fetch request; IADDR  output  30  word fetch address; INSTR  input  32  instruction word for the current IADDR, valid in the same cycle.
REQ-003 SHALL: REDIR_VALID  input  1  taken branch/jump from EX; REDIR_PC  input  30  word target address.
REQ-004 SHALL: RA0, RA1  output  5 each  register-file read addresses; DOUT0, DOUT1  input  32 each  read data.
REQ-005 SHALL: WB_WEN  input  1, WB_WA  input  5, WB_DI  input  32  write-back port mirror, used for same-cycle bypass.
REQ-006 SHALL: ID_VALID  output  1, ID_OP  output  5, ID_INSTR  output  32, ID_IADDR  output  30, ID_DEST  output  5, ID_WEN  output  1, ID_VALA  output  32, ID_VALB  output  32, ID_IMM  output  32  registered ID/EX bundle; STALL  output  1  load-use bubble this cycle.

Function
REQ-007 SHALL: fields decode as opcode=INSTR[31:27], ra=[26:22], rb=[21:17], rc=[16:12], imm17=[16:0], imm22=[21:0], shamt=[4:0], cond=[2:0].
REQ-008 SHALL: opcodes ADDI=0, ANDI=1, ORI=2, MOVI=3, ADD=4, SUB=5, NEG=6, NOT=7, AND=8, OR=9, XOR=10, LSR=11, ASR=12, SHL=13, ROR=14, BR=15, BRL=16, J=17, JL=18, LD=19, LDR=20, ST=21, STR=22; opcodes 23-31 decode as NOP (ID_WEN=0).
REQ-009 SHALL: a PC register drive IADDR; each non-stalled, non-redirected cycle PC <= PC+1, with 30-bit wrap from 3FFFFFFF to 0.
REQ-010 SHALL: an IF/ID register capture {INSTR, IADDR, valid=1} each non-stalled cycle.
REQ-011 SHALL: read addresses be RA0=rb; RA1=ra for ST, STR, BR, BRL (store data or branch operand), else rc.
REQ-012 SHALL: ID_VALA come from RA0 and ID_VALB from RA1, each replaced by WB_DI when WB_WEN=1 and WB_WA equals that read address.
REQ-013 SHALL: ID_IMM be sign-extended imm22 for J, JL, LDR, STR; zero-extended shamt for LSR, ASR, SHL, ROR; else sign-extended imm17.
REQ-014 SHALL: ID_DEST=ra; ID_WEN=1 only for opcodes 0-14, BRL, JL, LD, LDR, and only when ID_VALID=1.
REQ-015 SHALL: load-use hazard = ID/EX holds valid LD/LDR with ID_WEN=1 and ID_DEST equal to an address on RA0 or RA1 used by the IF/ID instruction; then STALL=1, PC and IF/ID hold, ID/EX loads a bubble (ID_VALID=0, ID_WEN=0), exactly one cycle.
REQ-016 SHALL: on REDIR_VALID=1, PC <= REDIR_PC at the next edge, IF/ID and ID/EX both load bubbles; redirect has priority over stall.
REQ-017 SHALL: have three states: RST (IREQ=0), START (first cycle after reset release, IREQ=1, PC=0, IF/ID empty), RUN (IREQ=1); RST->START on the first edge with RSTN high, START->RUN unconditionally.
REQ-018 SHALL: keep IREQ=1 during stall and re-present the same IADDR.
REQ-019 SHALL: produce a bubble on ID/EX when IF/ID valid=0, with no hazard evaluation.

Reset
REQ-020 SHALL: on RSTN low, immediately set PC=0, state=RST, IF/ID valid=0, IF/ID instr=0; all ID_* outputs 0; IREQ=0; STALL=0.
REQ-021 SHALL: drop all in-flight instructions when reset is asserted mid-operation; fetch restarts at IADDR=0 via START.

Structure
REQ-022 SHALL: place opcode constants, field bit positions and the state encoding in shared package toy_pkg.
REQ-023 SHALL: place the combinational decoder (REQ-008, 011, 013, 014) in sub-module toy_decode; the hazard, PC, state machine and pipeline registers remain in toy_frontend.

Verification
REQ-024 SHALL: cover straight-line code: ADDI r1,r0,5 at word 0 -> ID_VALID=1, ID_OP=0, ID_IMM=5, ID_DEST=1 two edges after reset release; IADDR increments by 1 per cycle.
REQ-025 SHALL: cover load-use: LD r2,[r3+0] followed by ADD r4,r2,r5 -> STALL=1 for one cycle, IADDR held, one bubble, then ADD issues with RA0=2.
REQ-026 SHALL: cover redirect: REDIR_VALID=1, REDIR_PC=0x100 while a stall condition is present -> next IADDR=0x100, two bubbles, no STALL cycle.
REQ-027 SHALL: cover bypass: WB_WEN=1, WB_WA=7, WB_DI=0xDEADBEEF with DOUT0=0 while ADD rb=7 decodes -> ID_VALA=0xDEADBEEF.
REQ-028 SHALL: cover immediates: J with imm22=0x3FFFFF -> ID_IMM=0xFFFFFFFF; ADDI with imm17=0x10000 -> ID_IMM=0xFFFF0000; SHL shamt=31 -> ID_IMM=31.
REQ-029 SHALL: cover reset mid-run: RSTN pulsed low during a stall -> IREQ=0 and ID_VALID=0 immediately, IADDR=0 in START, normal fetch resumes.
